input_debouncer: RTL and testbench

Conditions a raw asynchronous level, such as a push-button or an external strobe, into a clean, glitch-free single-bit signal. That signal drives the `d_i` of the DFF stage directly downstream. The block synchronizes the input through a flop chain and filters it with a stability counter. It produces a debounced level plus optional one-cycle rise and fall pulses.

---
 rtl/input_debouncer.sv | 143 ++++++++++++++
 tb/tb_input_debouncer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw asynchronous level into a clean q_o.
// Define INPUT_DEBOUNCER_EDGE_EN to build the rise_o/fall_o pulse registers.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam bit FAST = (STABLE_CYCLES == 1);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] CNT_HI  = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] CNT_LO  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          cnt_inc;
  logic                   q_q, q_d;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_ONE;

  // Synchronizer chain, d_i enters at bit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Next-state: the glitch check takes priority over count completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE_LO: begin
        if (sync) begin
          if (FAST) begin
            state_d = IDLE_HI;
            q_d     = 1'b1;
          end else begin
            state_d = CNT_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CNT_HI: begin
        if (!sync) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = IDLE_HI;
          q_d     = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      IDLE_HI: begin
        if (!sync) begin
          if (FAST) begin
            state_d = IDLE_LO;
            q_d     = 1'b0;
          end else begin
            state_d = CNT_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CNT_LO: begin
        if (sync) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = IDLE_LO;
          q_d     = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
  end

  // FSM, stability counter and debounced level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign q_o    = q_q;
  assign busy_o = (state_q == CNT_HI) || (state_q == CNT_LO);

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic rise_q, fall_q;
  logic rise_d, fall_d;

  assign rise_d = q_d & ~q_q;
  assign fall_d = ~q_d & q_q;

  // One-cycle pulses aligned with the q_o change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: default build plus a
// SYNC_STAGES=3 / STABLE_CYCLES=1 instance.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d = 1'b1;
  logic d1 = 1'b0;
  logic q, r, f, b;
  logic q1, r1, f1, b1;

  int n_tests = 0;
  int n_fail = 0;

  // expected {q, rise, fall, busy} after the next rising edge
  logic [3:0] exp_q[$];
  logic [3:0] exp1_q[$];

  always #5 clk = ~clk;

  input_debouncer u_dut (
    .clk(clk), .reset(reset), .d_i(d),
    .q_o(q), .rise_o(r), .fall_o(f), .busy_o(b)
  );

  input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .d_i(d1),
    .q_o(q1), .rise_o(r1), .fall_o(f1), .busy_o(b1)
  );

  function automatic logic [3:0] m(input logic [3:0] e);
    return EDGE ? e : (e & 4'b1001);
  endfunction

  task automatic check(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got qrfb=%b expected %b",
               nm, n_tests, act, exp);
    end
  endtask

  // monitor: pops one expectation per edge for each instance
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("main", {q, r, f, b}, exp_q.pop_front());
    if (exp1_q.size() > 0) check("fast", {q1, r1, f1, b1}, exp1_q.pop_front());
  end

  task automatic step(input logic dv, input logic [3:0] e);
    @(negedge clk);
    d = dv;
    exp_q.push_back(m(e));
  endtask

  task automatic step1(input logic dv, input logic [3:0] e);
    @(negedge clk);
    d1 = dv;
    exp1_q.push_back(m(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held with d_i=1
    step(1, 4'b0000);
    step(1, 4'b0000);
    step(1, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    d = 1'b1;
    exp_q.push_back(m(4'b0000));
    // clean rise
    step(1, 4'b0000);
    step(1, 4'b0001);
    step(1, 4'b0001);
    step(1, 4'b0001);
    step(1, 4'b1100);
    step(1, 4'b1000);
    step(1, 4'b1000);
    // clean fall
    step(0, 4'b1000);
    step(0, 4'b1000);
    step(0, 4'b1001);
    step(0, 4'b1001);
    step(0, 4'b1001);
    step(0, 4'b0010);
    step(0, 4'b0000);
    // 2-cycle glitch
    step(1, 4'b0000);
    step(1, 4'b0000);
    step(0, 4'b0001);
    step(0, 4'b0001);
    step(0, 4'b0000);
    step(0, 4'b0000);
    // 3-cycle pulse: drops on the edge the count would complete
    step(1, 4'b0000);
    step(1, 4'b0000);
    step(1, 4'b0001);
    step(0, 4'b0001);
    step(0, 4'b0001);
    step(0, 4'b0000);
    step(0, 4'b0000);
    // exactly 4-cycle pulse is accepted, then falls back
    step(1, 4'b0000);
    step(1, 4'b0000);
    step(1, 4'b0001);
    step(1, 4'b0001);
    step(0, 4'b0001);
    step(0, 4'b1100);
    step(0, 4'b1001);
    step(0, 4'b1001);
    step(0, 4'b1001);
    step(0, 4'b0010);
    step(0, 4'b0000);
    // async reset mid-count
    step(1, 4'b0000);
    step(1, 4'b0000);
    step(1, 4'b0001);
    step(1, 4'b0001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_async", {q, r, f, b}, 4'b0000);
    @(negedge clk);
    check("rst_hold", {q, r, f, b}, 4'b0000);
    reset = 1'b1;
    d = 1'b1;
    exp_q.push_back(m(4'b0000));
    step(1, 4'b0000);
    step(1, 4'b0001);
    step(1, 4'b0001);
    step(1, 4'b0001);
    step(1, 4'b1100);
    step(1, 4'b1000);
    // single-cycle filter, three sync stages
    step1(1, 4'b0000);
    step1(1, 4'b0000);
    step1(1, 4'b0000);
    step1(1, 4'b1100);
    step1(1, 4'b1000);
    step1(0, 4'b1000);
    step1(0, 4'b1000);
    step1(0, 4'b1000);
    step1(0, 4'b0010);
    step1(0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    check("drain", {2'b00, exp_q.size() != 0, exp1_q.size() != 0}, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
